// File: rtl/matvec_pkg.sv
// Shared definitions for the matrix/vector group sharing arbiter.
//   - width helpers for the matrix, vector and value-size buses
//   - requester tag width helper
//   - input-side FSM state encoding
package matvec_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Matrix bus width: VECTOR_SIZE^2 entries of ENTRY_SIZE bits.
  function automatic int mat_w(input int vector_size, input int entry_size);
    return vector_size * vector_size * entry_size;
  endfunction

  // Vector bus width: VECTOR_SIZE entries of ENTRY_SIZE bits.
  function automatic int vec_w(input int vector_size, input int entry_size);
    return vector_size * entry_size;
  endfunction

  // Value-size header width in bits.
  function automatic int size_w(input int value_size_bytes);
    return 8 * value_size_bytes;
  endfunction

  // Requester tag width; NUM_REQ is at least 2 so this is at least 1.
  function automatic int tag_w(input int num_req);
    return $clog2(num_req);
  endfunction

endpackage

// File: rtl/matvec_tag_fifo.sv
// Circular FIFO holding the requester tag of every granted packet, in grant
// order, until its result packet has been routed back.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   push        write push_data (ignored when full)
//   push_data   tag to store
//   pop         drop the head entry (ignored when empty)
//   head        tag at the head of the queue
//   full/empty  registered occupancy flags
//   count       number of stored tags (0 .. 2**AW)
module matvec_tag_fifo #(
  parameter int W  = 2,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Simultaneous push and pop leaves the count unchanged.
    count_d = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/matvec_share_arbiter.sv
// Shares one matrix-vector multiplication group between NUM_REQ packet
// streams. Whole packets are granted round-robin; each grant's requester tag
// is queued so the result packets can be routed back in order.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   req_matrix_data/vector_data/
//     value_size/valid/last, req_ready per-requester input streams (slice k)
//   grp_matrix_data/vector_data/
//     value_size/valid/last, grp_ready  packet stream into the group
//   grp_out_data/value_size/valid/
//     last, grp_out_ready               result stream from the group
//   rsp_data/value_size/last          results broadcast to all requesters
//   rsp_valid, rsp_ready              per-requester result handshake
//   inflight                          tags currently queued
//   err_orphan                        sticky: result seen with no tag queued
//   dbg_state                         input FSM state
//
// Handshake rule on every stream: a beat transfers on a cycle where valid and
// ready are both high; valid, once raised, is held with stable data until the
// transfer, and ready may depend combinationally on valid.
module matvec_share_arbiter
  import matvec_pkg::*;
#(
  parameter int NUM_REQ             = 4,
  parameter int VECTOR_SIZE         = 3,
  parameter int ENTRY_SIZE          = 64,
  parameter int VALUE_SIZE_BYTES_NO = 2,
  parameter int TAG_ADDR_BITS       = 4,
  localparam int MW = mat_w(VECTOR_SIZE, ENTRY_SIZE),
  localparam int VW = vec_w(VECTOR_SIZE, ENTRY_SIZE),
  localparam int SW = size_w(VALUE_SIZE_BYTES_NO)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ*MW-1:0]   req_matrix_data,
  input  logic [NUM_REQ*VW-1:0]   req_vector_data,
  input  logic [NUM_REQ*SW-1:0]   req_value_size,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_last,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [MW-1:0]           grp_matrix_data,
  output logic [VW-1:0]           grp_vector_data,
  output logic [SW-1:0]           grp_value_size,
  output logic                    grp_valid,
  output logic                    grp_last,
  input  logic                    grp_ready,
  input  logic [VW-1:0]           grp_out_data,
  input  logic [SW-1:0]           grp_out_value_size,
  input  logic                    grp_out_valid,
  input  logic                    grp_out_last,
  output logic                    grp_out_ready,
  output logic [VW-1:0]           rsp_data,
  output logic [SW-1:0]           rsp_value_size,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic                    rsp_last,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [TAG_ADDR_BITS:0]  inflight,
  output logic                    err_orphan,
  output state_e                  dbg_state
);

  localparam int TAG_W = tag_w(NUM_REQ);

  state_e           state_q, state_d;
  logic [TAG_W-1:0] grant_q, grant_d;
  logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             first_q, first_d;
  logic [SW-1:0]    vs_q, vs_d;
  logic             err_orphan_q, err_orphan_d;

  logic             found;
  logic [TAG_W-1:0] pick;
  logic             tag_push, tag_pop;
  logic [TAG_W-1:0] tag_head;
  logic             tag_full, tag_empty;

  // Round-robin scan: first requesting slot at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
        found = 1'b1;
        pick  = TAG_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      end
    end
  end

  // Input FSM. IDLE always spends one cycle per packet, so a grant never
  // depends combinationally on the previous packet's last beat. The value
  // size is passed through on the first beat and held for the remaining beats.
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    rr_ptr_d        = rr_ptr_q;
    first_d         = first_q;
    vs_d            = vs_q;
    tag_push        = 1'b0;
    req_ready       = '0;
    grp_valid       = 1'b0;
    grp_last        = 1'b0;
    grp_matrix_data = '0;
    grp_vector_data = '0;
    grp_value_size  = '0;
    case (state_q)
      IDLE: begin
        // tag_full is the registered flag, so a pop in this cycle does not
        // open a slot until the next one.
        if (found && !tag_full) begin
          state_d  = GRANT;
          grant_d  = pick;
          tag_push = 1'b1;
          rr_ptr_d = (int'(pick) == NUM_REQ - 1) ? '0 : pick + TAG_W'(1);
          first_d  = 1'b1;
        end
      end
      GRANT: begin
        grp_valid       = req_valid[grant_q];
        grp_last        = req_last[grant_q];
        grp_matrix_data = req_matrix_data[int'(grant_q)*MW +: MW];
        grp_vector_data = req_vector_data[int'(grant_q)*VW +: VW];
        grp_value_size  = first_q ? req_value_size[int'(grant_q)*SW +: SW] : vs_q;
        req_ready[grant_q] = grp_ready;
        if (grp_valid && grp_ready) begin
          if (first_q) begin
            vs_d    = req_value_size[int'(grant_q)*SW +: SW];
            first_d = 1'b0;
          end
          if (grp_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result routing: only the requester at the head of the tag queue sees
  // rsp_valid, and only its ready reaches the group.
  always_comb begin
    rsp_valid     = '0;
    grp_out_ready = 1'b0;
    tag_pop       = 1'b0;
    err_orphan_d  = err_orphan_q;
    if (!tag_empty) begin
      rsp_valid[tag_head] = grp_out_valid;
      grp_out_ready       = rsp_ready[tag_head];
      tag_pop             = grp_out_valid & rsp_ready[tag_head] & grp_out_last;
    end else if (grp_out_valid) begin
      err_orphan_d = 1'b1;
    end
  end

  assign rsp_data       = grp_out_data;
  assign rsp_value_size = grp_out_value_size;
  assign rsp_last       = grp_out_last;
  assign err_orphan     = err_orphan_q;
  assign dbg_state      = state_q;

  matvec_tag_fifo #(
    .W  (TAG_W),
    .AW (TAG_ADDR_BITS)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_push),
    .push_data (pick),
    .pop       (tag_pop),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (inflight)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      first_q      <= 1'b0;
      vs_q         <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      first_q      <= first_d;
      vs_q         <= vs_d;
      err_orphan_q <= err_orphan_d;
    end
  end

endmodule
